// File: rtl/fp_normalizer_l.sv
// fp_normalizer_l: post-add normalization for the half-precision adder.
// Takes the raw mantissa sum (carry-out bit plus hidden position) and the
// pre-adjust exponent. It renormalizes with either a right-by-1 correction
// or a leading-zero-driven left barrel shift. Three pipeline stages with a
// global valid/ready stall.
// Optional feature: define NORM_DENORM_EN to produce subnormals on exponent
// underflow. Without it, underflowed results are flushed to zero.
//
// Handshake: a beat is taken when in_valid && in_ready. A result leaves when
// out_valid && out_ready. in_ready = !(out_valid && !out_ready). While
// stalled, every stage holds, so bubbles are kept and outputs stay stable.
module fp_normalizer_l #(
    parameter int MAN_W = 11,
    parameter int EXP_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [MAN_W:0]   in_man,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [MAN_W-1:0] out_man,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_zero,
    output logic             out_ovf,
    output logic             out_unf
);

    localparam int LZW = $clog2(MAN_W + 1);
    // Compare/shift width wide enough for both lz and the exponent
    localparam int CW  = ((LZW > EXP_W) ? LZW : EXP_W) + 1;
    localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    function automatic logic [LZW-1:0] count_lz(input logic [MAN_W-1:0] v);
        logic [LZW-1:0] n;
        logic           found;
        n     = '0;
        found = 1'b0;
        for (int i = MAN_W - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + LZW'(1);
            end
        end
        return n;
    endfunction

    logic en;
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    // Stage 1 state
    logic             s1_valid, s1_sign;
    logic [MAN_W:0]   s1_man;
    logic [EXP_W-1:0] s1_exp;
    logic [LZW-1:0]   s1_lz;

    // Stage 2 state
    logic             s2_valid, s2_sign, s2_zero, s2_ovf, s2_unf;
    logic [MAN_W-1:0] s2_man;
    logic [EXP_W-1:0] s2_exp;

    // Stage 2 combinational results
    logic [EXP_W:0]   exp_inc;
    logic [CW-1:0]    lz_ext, exp_ext, shamt;
    logic             is_carry, is_zero, is_norm;
    logic [MAN_W-1:0] shifted;
    logic [MAN_W-1:0] n_man;
    logic [EXP_W-1:0] n_exp;
    logic             n_zero, n_ovf, n_unf;

    // S1: capture the beat, carry is implicit in s1_man[MAN_W], count leading zeros
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_man   <= '0;
            s1_exp   <= '0;
            s1_lz    <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_sign  <= in_sign;
            s1_man   <= in_man;
            s1_exp   <= in_exp;
            s1_lz    <= count_lz(in_man[MAN_W-1:0]);
        end
    end

    // S2 decode: classify the beat and pick the left-shift amount
    always_comb begin
        exp_inc  = {1'b0, s1_exp} + (EXP_W + 1)'(1);
        lz_ext   = CW'(s1_lz);
        exp_ext  = CW'(s1_exp);
        is_carry = s1_man[MAN_W];
        is_zero  = (s1_man == '0);
        is_norm  = (lz_ext < exp_ext);
        shamt    = lz_ext;
`ifdef NORM_DENORM_EN
        // Subnormal: shift only as far as the exponent allows (exp field becomes 0)
        if (!is_carry && !is_zero && !is_norm)
            shamt = (s1_exp == '0) ? '0 : exp_ext - CW'(1);
`endif
    end

    // S2 barrel shifter: one mux layer per shift-amount bit, zero fill at LSB
    always_comb begin
        shifted = s1_man[MAN_W-1:0];
        for (int k = 0; k < CW; k++) begin
            if (shamt[k]) begin
                if ((1 << k) >= MAN_W) shifted = '0;
                else                   shifted = shifted << (1 << k);
            end
        end
    end

    // S2 result select: carry, zero, normal, underflow (flags mutually exclusive)
    always_comb begin
        n_man  = '0;
        n_exp  = '0;
        n_zero = 1'b0;
        n_ovf  = 1'b0;
        n_unf  = 1'b0;
        if (is_carry) begin
            if (exp_inc >= EXP_MAX) begin
                n_exp = '1;
                n_ovf = 1'b1;
            end else begin
                n_man = s1_man[MAN_W:1];
                n_exp = exp_inc[EXP_W-1:0];
            end
        end else if (is_zero) begin
            n_zero = 1'b1;
        end else if (is_norm) begin
            n_man = shifted;
            n_exp = s1_exp - EXP_W'(s1_lz);
        end else begin
            n_unf = 1'b1;
`ifdef NORM_DENORM_EN
            n_man = shifted;
`endif
        end
    end

    // S2 register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_man   <= '0;
            s2_exp   <= '0;
            s2_zero  <= 1'b0;
            s2_ovf   <= 1'b0;
            s2_unf   <= 1'b0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_man   <= n_man;
            s2_exp   <= n_exp;
            s2_zero  <= n_zero;
            s2_ovf   <= n_ovf;
            s2_unf   <= n_unf;
        end
    end

    // S3: output register, held while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_man   <= '0;
            out_exp   <= '0;
            out_zero  <= 1'b0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
        end else if (en) begin
            out_valid <= s2_valid;
            out_sign  <= s2_sign;
            out_man   <= s2_man;
            out_exp   <= s2_exp;
            out_zero  <= s2_zero;
            out_ovf   <= s2_ovf;
            out_unf   <= s2_unf;
        end
    end

endmodule
